// File: rtl/exp_step_counter_if.sv
// ============================================================================
// exp_step_counter_if : load/step request and status bundle for exp_step_counter
// Rev 1.0
// ============================================================================
`default_nettype none

interface exp_step_counter_if #(
   parameter int WIDTH  = 5,
   parameter int STEP_W = 4
);
   logic              load_valid;
   logic [WIDTH-1:0]  load_value;
   logic              step_valid;
   logic              step_dir;
   logic [STEP_W-1:0] step_amount;
   logic              step_ready;
   logic [WIDTH-1:0]  count;
   logic              done;
   logic              carry_out;
   logic              borrow_out;
   logic              at_max;
   logic              at_min;

   modport master (
      output load_valid, load_value, step_valid, step_dir, step_amount,
      input  step_ready, count, done, carry_out, borrow_out, at_max, at_min
   );

   modport slave (
      input  load_valid, load_value, step_valid, step_dir, step_amount,
      output step_ready, count, done, carry_out, borrow_out, at_max, at_min
   );
endinterface

`default_nettype wire

// File: rtl/exp_step_counter.sv
// ============================================================================
// exp_step_counter : registered up/down counter applying multi-unit step requests
// Rev 1.0
// ============================================================================
`default_nettype none

module exp_step_counter #(
   parameter int WIDTH    = 5,
   parameter int STEP_W   = 4,
   parameter int SATURATE = 1
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   exp_step_counter_if.slave   bus
);
   localparam logic [0:0]       ST_IDLE = 1'b0;
   localparam logic [0:0]       ST_STEP = 1'b1;
   localparam logic [WIDTH-1:0] C_MAX   = {WIDTH{1'b1}};

   logic [0:0]        r_state;
   logic [WIDTH-1:0]  r_count;
   logic [STEP_W-1:0] r_remaining;
   logic              r_dir;
   logic              r_done;
   logic              r_carry;
   logic              r_borrow;

   logic              w_idle;
   logic              w_accept;
   logic              w_unit;
   logic              w_dir;
   logic              w_at_lim;
   logic              w_clamp;
   logic              w_finish;
   logic              w_carry;
   logic              w_borrow;
   logic [STEP_W-1:0] w_left;
   logic [WIDTH-1:0]  w_step_count;

   generate
      if (SATURATE != 0) begin : g_sat
         assign w_clamp = w_at_lim;
      end else begin : g_wrap
         assign w_clamp = 1'b0;
      end
   endgenerate

   always_comb begin
      w_idle       = (r_state == ST_IDLE);
      w_accept     = w_idle & bus.step_valid & ~bus.load_valid;
      // A unit is applied on the accept edge itself, and on every STEP edge.
      w_unit       = ~bus.load_valid &
                     ((w_accept & (bus.step_amount != '0)) | ~w_idle);
      w_dir        = w_idle ? bus.step_dir : r_dir;
      w_at_lim     = w_dir ? (r_count == '0) : (r_count == C_MAX);
      w_left       = w_idle ? (bus.step_amount - 1'b1) : (r_remaining - 1'b1);
      w_step_count = w_dir ? (r_count - 1'b1) : (r_count + 1'b1);
      w_carry      = (r_carry  & ~w_accept) | (w_unit & w_at_lim & ~w_dir);
      w_borrow     = (r_borrow & ~w_accept) | (w_unit & w_at_lim &  w_dir);
      w_finish     = w_unit & (w_clamp | (w_left == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_remaining <= '0;
         r_dir       <= 1'b0;
         r_done      <= 1'b0;
         r_carry     <= 1'b0;
         r_borrow    <= 1'b0;
      end else if (bus.load_valid) begin
         r_state     <= ST_IDLE;
         r_count     <= bus.load_value;
         r_remaining <= '0;
         r_done      <= 1'b0;
         r_carry     <= 1'b0;
         r_borrow    <= 1'b0;
      end else begin
         r_carry  <= w_carry;
         r_borrow <= w_borrow;
         r_done   <= w_finish | (w_accept & (bus.step_amount == '0));
         if (w_accept) begin
            r_dir <= bus.step_dir;
         end
         if (w_unit) begin
            if (!w_clamp) begin
               r_count <= w_step_count;
            end
            if (w_finish) begin
               r_state     <= ST_IDLE;
               r_remaining <= '0;
            end else begin
               r_state     <= ST_STEP;
               r_remaining <= w_left;
            end
         end
      end
   end

   assign bus.step_ready = w_idle;
   assign bus.count      = r_count;
   assign bus.done       = r_done;
   assign bus.carry_out  = r_carry;
   assign bus.borrow_out = r_borrow;
   assign bus.at_max     = (r_count == C_MAX);
   assign bus.at_min     = (r_count == '0);
endmodule

`default_nettype wire

// File: tb/tb_exp_step_counter.sv
// ============================================================================
// tb_exp_step_counter : wrap and saturate instances checked against a unit-count model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exp_step_counter;
   localparam int W    = 5;
   localparam int SW   = 4;
   localparam int MAXV = 31;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   exp_step_counter_if #(.WIDTH(W), .STEP_W(SW)) bw ();
   exp_step_counter_if #(.WIDTH(W), .STEP_W(SW)) bs ();

   exp_step_counter #(.WIDTH(W), .STEP_W(SW), .SATURATE(0)) u_wrap (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bw.slave)
   );

   exp_step_counter #(.WIDTH(W), .STEP_W(SW), .SATURATE(1)) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bs.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: index 0 = wrapping counter, 1 = saturating counter.
   int m_cnt  [2];
   int m_left [2];
   int m_dir  [2];
   int m_cy   [2];
   int m_bo   [2];
   int m_done [2];

   task automatic model_reset();
      for (int v = 0; v < 2; v++) begin
         m_cnt[v] = 0; m_left[v] = 0; m_dir[v] = 0;
         m_cy[v] = 0; m_bo[v] = 0; m_done[v] = 0;
      end
   endtask

   task automatic model_edge(input int lv, input int lval, input int sv,
                             input int sd, input int sa);
      int hit;
      for (int v = 0; v < 2; v++) begin
         m_done[v] = 0;
         if (lv != 0) begin
            m_cnt[v] = lval; m_left[v] = 0; m_cy[v] = 0; m_bo[v] = 0;
         end else begin
            if (m_left[v] == 0 && sv != 0) begin
               m_cy[v] = 0; m_bo[v] = 0; m_dir[v] = sd; m_left[v] = sa;
               if (sa == 0) m_done[v] = 1;
            end
            if (m_left[v] > 0) begin
               hit = (m_dir[v] != 0) ? int'(m_cnt[v] == 0) : int'(m_cnt[v] == MAXV);
               if (hit != 0) begin
                  if (m_dir[v] != 0) m_bo[v] = 1;
                  else               m_cy[v] = 1;
               end
               if (hit != 0 && v == 1) begin
                  m_left[v] = 0;
               end else begin
                  m_cnt[v]  = (m_cnt[v] + ((m_dir[v] != 0) ? -1 : 1) + 32) % 32;
                  m_left[v] = m_left[v] - 1;
               end
               if (m_left[v] == 0) m_done[v] = 1;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_dut(input string tag, input int v, input logic [31:0] cnt,
                            input logic [31:0] rdy, input logic [31:0] dn,
                            input logic [31:0] cy, input logic [31:0] bo,
                            input logic [31:0] mx, input logic [31:0] mn);
      string p;
      p = (v == 0) ? "wrap" : "sat";
      chk($sformatf("%s/%s/count", tag, p), cnt, m_cnt[v]);
      chk($sformatf("%s/%s/step_ready", tag, p), rdy, (m_left[v] == 0) ? 1 : 0);
      chk($sformatf("%s/%s/done", tag, p), dn, m_done[v]);
      chk($sformatf("%s/%s/carry_out", tag, p), cy, m_cy[v]);
      chk($sformatf("%s/%s/borrow_out", tag, p), bo, m_bo[v]);
      chk($sformatf("%s/%s/at_max", tag, p), mx, (m_cnt[v] == MAXV) ? 1 : 0);
      chk($sformatf("%s/%s/at_min", tag, p), mn, (m_cnt[v] == 0) ? 1 : 0);
   endtask

   task automatic check_all(input string tag);
      check_dut(tag, 0, bw.count, bw.step_ready, bw.done, bw.carry_out,
                bw.borrow_out, bw.at_max, bw.at_min);
      check_dut(tag, 1, bs.count, bs.step_ready, bs.done, bs.carry_out,
                bs.borrow_out, bs.at_max, bs.at_min);
   endtask

   task automatic drive(input int lv, input int lval, input int sv,
                        input int sd, input int sa);
      logic [31:0] lv32;
      logic [31:0] sa32;
      lv32 = lval;
      sa32 = sa;
      bw.load_valid  = (lv != 0); bs.load_valid  = (lv != 0);
      bw.load_value  = lv32[W-1:0]; bs.load_value  = lv32[W-1:0];
      bw.step_valid  = (sv != 0); bs.step_valid  = (sv != 0);
      bw.step_dir    = (sd != 0); bs.step_dir    = (sd != 0);
      bw.step_amount = sa32[SW-1:0]; bs.step_amount = sa32[SW-1:0];
   endtask

   task automatic cycle(input string tag, input int lv, input int lval,
                        input int sv, input int sd, input int sa);
      drive(lv, lval, sv, sd, sa);
      @(posedge clk);
      model_edge(lv, lval, sv, sd, sa);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int lv, lval, sv, sd, sa, pick;
      errors = 0;
      checks = 0;
      drive(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      rst_n = 1'b1;

      cycle("basic_load", 1, 5, 0, 0, 0);
      cycle("basic_accept", 0, 0, 1, 0, 3);
      idle("basic_run", 3);
      chk("basic_final_count", bw.count, 8);

      cycle("wrap_load", 1, 30, 0, 0, 0);
      cycle("wrap_accept", 0, 0, 1, 0, 4);
      idle("wrap_run", 4);
      chk("wrap_up_count", bw.count, 2);
      chk("wrap_up_carry", bw.carry_out, 1);
      cycle("wrapdn_load", 1, 1, 0, 0, 0);
      cycle("wrapdn_accept", 0, 0, 1, 1, 3);
      idle("wrapdn_run", 3);
      chk("wrap_dn_count", bw.count, 30);
      chk("wrap_dn_borrow", bw.borrow_out, 1);

      cycle("sat_load", 1, 2, 0, 0, 0);
      cycle("sat_accept", 0, 0, 1, 1, 5);
      idle("sat_run", 4);
      chk("sat_count", bs.count, 0);
      chk("sat_borrow", bs.borrow_out, 1);

      cycle("zero_step", 0, 0, 1, 0, 0);
      idle("zero_after", 1);
      cycle("b2b_load", 1, 7, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle("b2b_step", 0, 0, 1, 0, 1);
      idle("b2b_after", 1);
      chk("b2b_count", bw.count, 11);

      cycle("abort_load", 1, 0, 0, 0, 0);
      cycle("abort_accept", 0, 0, 1, 0, 10);
      idle("abort_run", 3);
      chk("abort_mid_count", bw.count, 4);
      cycle("abort_load20", 1, 20, 1, 0, 3);
      idle("abort_after", 2);
      chk("abort_count", bw.count, 20);

      cycle("arst_load", 1, 0, 0, 0, 0);
      cycle("arst_accept", 0, 0, 1, 0, 10);
      idle("arst_run", 1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      @(posedge clk);
      #1;
      check_all("reset_held");
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         lv   = ($urandom_range(0, 9) == 0) ? 1 : 0;
         pick = $urandom_range(0, 3);
         lval = (pick == 0) ? 0 : (pick == 1) ? MAXV : (pick == 2) ? MAXV - 1
                : $urandom_range(0, MAXV);
         sv   = $urandom_range(0, 1);
         sd   = $urandom_range(0, 1);
         sa   = $urandom_range(0, 15);
         cycle("random", lv, lval, sv, sd, sa);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
